// File: rtl/accum_exec_unit.sv
// Execution unit fed by the operand accumulator: captures r0..r2 on op_en, runs
// single-cycle ALU ops or an iterative shift-add MUL/MAC, and hands results to writeback.
module accum_exec_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             put_en,
  input  logic             op_en,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] r0,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic             result_ready,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             err_operands,
  output logic             err_overrun
);

  localparam int IW = $clog2(WIDTH) + 1;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_MAC = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r, state_next_s;

  function automatic logic [CNT_W-1:0] req_count(input logic [3:0] op);
    case (op)
      4'd0, 4'd6:                                     req_count = CNT_W'(1);
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd10: req_count = CNT_W'(2);
      4'd9, 4'd11:                                    req_count = CNT_W'(3);
      default:                                        req_count = CNT_W'(0);
    endcase
  endfunction

  logic [CNT_W-1:0]   cnt_r;
  logic [3:0]         op_r;
  logic [2*WIDTH-1:0] mcand_r, prod_r, prod_step_s;
  logic [WIDTH-1:0]   mplier_r, addend_r;
  logic [IW-1:0]      iter_r;
  logic [2*WIDTH:0]   mac_full_s;
  logic               accept_s, enough_s, is_mul_s, last_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_c_s;
  logic [WIDTH:0]     sum2_s, diff_s, shl_s, shr_s;
  logic [WIDTH+1:0]   sum3_s;

  assign accept_s    = (state_r == IDLE) && op_en && !put_en;
  assign enough_s    = (cnt_r >= req_count(opcode));
  assign is_mul_s    = (opcode == OP_MUL) || (opcode == OP_MAC);
  assign last_s      = (iter_r == IW'(WIDTH - 1));
  assign prod_step_s = prod_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
  assign mac_full_s  = {1'b0, prod_step_s} + {{(WIDTH+1){1'b0}}, addend_r};

  // Shifts carry one guard bit so the last bit shifted out lands in a fixed position.
  assign sum2_s = {1'b0, r0} + {1'b0, r1};
  assign diff_s = {1'b0, r0} - {1'b0, r1};
  assign sum3_s = {2'b00, r0} + {2'b00, r1} + {2'b00, r2};
  assign shl_s  = {1'b0, r0} << r1[2:0];
  assign shr_s  = {r0, 1'b0} >> r1[2:0];

  // Single-cycle ALU result and carry for the opcode presented with op_en.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    case (opcode)
      4'd0: alu_res_s = r0;
      4'd1: begin alu_res_s = sum2_s[WIDTH-1:0]; alu_c_s = sum2_s[WIDTH]; end
      4'd2: begin alu_res_s = diff_s[WIDTH-1:0]; alu_c_s = diff_s[WIDTH]; end
      4'd3: alu_res_s = r0 & r1;
      4'd4: alu_res_s = r0 | r1;
      4'd5: alu_res_s = r0 ^ r1;
      4'd6: alu_res_s = ~r0;
      4'd7: begin alu_res_s = shl_s[WIDTH-1:0]; alu_c_s = shl_s[WIDTH]; end
      4'd8: begin alu_res_s = shr_s[WIDTH:1]; alu_c_s = shr_s[0]; end
      4'd9: begin alu_res_s = sum3_s[WIDTH-1:0]; alu_c_s = |sum3_s[WIDTH+1:WIDTH]; end
      default: begin alu_res_s = {WIDTH{1'b0}}; alu_c_s = 1'b0; end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && enough_s) begin
          state_next_s = is_mul_s ? ITER : DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ITER: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ITER;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, status outputs, error pulses and operand count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      err_operands <= 1'b0;
      err_overrun  <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_next_s;
      busy         <= (state_next_s != IDLE);
      result_valid <= (state_next_s == DONE);
      err_operands <= accept_s && !enough_s;
      err_overrun  <= (state_r != IDLE) && op_en;
      if (accept_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (put_en && !op_en && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Operand capture, multiply iteration and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= 4'd0;
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      addend_r <= {WIDTH{1'b0}};
      iter_r   <= {IW{1'b0}};
      result   <= {WIDTH{1'b0}};
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
    end else if ((state_r == IDLE) && accept_s && enough_s) begin
      op_r <= opcode;
      if (is_mul_s) begin
        mcand_r  <= {{WIDTH{1'b0}}, r0};
        mplier_r <= r1;
        prod_r   <= {(2*WIDTH){1'b0}};
        addend_r <= (opcode == OP_MAC) ? r2 : {WIDTH{1'b0}};
        iter_r   <= {IW{1'b0}};
      end else begin
        result <= alu_res_s;
        flag_z <= (alu_res_s == {WIDTH{1'b0}});
        flag_c <= alu_c_s;
      end
    end else if (state_r == ITER) begin
      prod_r   <= prod_step_s;
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      iter_r   <= iter_r + IW'(1);
      if (last_s) begin
        if (op_r == OP_MAC) begin
          result <= mac_full_s[WIDTH-1:0];
          flag_z <= (mac_full_s[WIDTH-1:0] == {WIDTH{1'b0}});
          flag_c <= |mac_full_s[2*WIDTH:WIDTH];
        end else begin
          result <= prod_step_s[WIDTH-1:0];
          flag_z <= (prod_step_s[WIDTH-1:0] == {WIDTH{1'b0}});
          flag_c <= |prod_step_s[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_accum_exec_unit.sv
// Self-checking bench for accum_exec_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_accum_exec_unit;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic put_en = 1'b0, op_en = 1'b0, result_ready = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [W-1:0] r0 = '0, r1 = '0, r2 = '0;
  logic busy, result_valid, flag_z, flag_c, err_operands, err_overrun;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_m = 0;

  accum_exec_unit #(.WIDTH(W), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .put_en(put_en), .op_en(op_en), .opcode(opcode),
    .r0(r0), .r1(r1), .r2(r2), .result_ready(result_ready), .busy(busy),
    .result_valid(result_valid), .result(result), .flag_z(flag_z), .flag_c(flag_c),
    .err_operands(err_operands), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int req_of(input int opc);
    case (opc)
      0, 6: return 1;
      1, 2, 3, 4, 5, 7, 8, 10: return 2;
      9, 11: return 3;
      default: return 0;
    endcase
  endfunction

  // Reference arithmetic on plain integers.
  function automatic void model(input int opc, input int a, input int b, input int c,
                                output int res, output int cf);
    int full;
    int s;
    full = 0;
    cf = 0;
    s = b % 8;
    case (opc)
      0: full = a;
      1: begin full = a + b; cf = (full > 255); end
      2: begin full = a - b + 256; cf = (a < b); end
      3: full = a & b;
      4: full = a | b;
      5: full = a ^ b;
      6: full = 255 - a;
      7: begin full = a * (1 << s); cf = (s == 0) ? 0 : ((a >> (8 - s)) & 1); end
      8: begin full = a / (1 << s); cf = (s == 0) ? 0 : ((a >> (s - 1)) & 1); end
      9: begin full = a + b + c; cf = (full > 255); end
      10: begin full = a * b; cf = (full > 255); end
      11: begin full = a * b + c; cf = (full > 255); end
      default: full = 0;
    endcase
    res = full % 256;
  endfunction

  task automatic do_op(input int opc, input int a, input int b, input int c,
                       input int nputs, input int hold, input int ovr_at);
    int exp_res, exp_c, k;
    repeat (nputs) begin
      @(negedge clk);
      put_en = 1'b1;
      if (cnt_m < 3) cnt_m++;
    end
    @(negedge clk);
    put_en = 1'b0;
    op_en = 1'b1;
    opcode = 4'(opc);
    r0 = W'(a); r1 = W'(b); r2 = W'(c);
    @(negedge clk);
    op_en = 1'b0;
    model(opc, a, b, c, exp_res, exp_c);
    k = 1;
    if (cnt_m < req_of(opc)) begin
      cnt_m = 0;
      check("err_operands", err_operands, 1);
      check("no_valid_on_err", result_valid, 0);
      check("idle_on_err", busy, 0);
      @(negedge clk);
      check("err_operands_pulse", err_operands, 0);
      return;
    end
    cnt_m = 0;
    check("no_err_operands", err_operands, 0);
    while (!result_valid && k < 40) begin
      check("busy_iter", busy, 1);
      op_en = (k == ovr_at);
      @(negedge clk);
      op_en = 1'b0;
      k++;
      if (ovr_at > 0 && k == ovr_at + 1) check("err_overrun", err_overrun, 1);
      if (ovr_at > 0 && k == ovr_at + 2) check("err_overrun_pulse", err_overrun, 0);
    end
    check("latency", k, (opc == 10 || opc == 11) ? W + 1 : 1);
    check("result", result, exp_res);
    check("flag_c", flag_c, exp_c);
    check("flag_z", flag_z, (exp_res == 0));
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", result_valid, 1);
      check("hold_result", result, exp_res);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("valid_dropped", result_valid, 0);
    check("back_idle", busy, 0);
  endtask

  initial begin
    int opc, a, b, c;
    repeat (2) @(negedge clk);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_flags", {flag_z, flag_c, err_operands, err_overrun}, 0);
    rst_n = 1'b1;

    // result_ready with nothing pending must be harmless
    @(negedge clk); result_ready = 1'b1;
    @(negedge clk); result_ready = 1'b0;
    check("ready_ignored", result_valid, 0);

    do_op(1, 200, 100, 0, 2, 3, 0);
    do_op(10, 13, 11, 0, 2, 0, 0);
    do_op(10, 16, 16, 0, 2, 0, 0);
    do_op(1, 7, 8, 0, 1, 0, 0);
    do_op(0, 9, 0, 0, 0, 0, 0);
    do_op(10, 13, 11, 0, 2, 5, 3);
    do_op(11, 20, 13, 5, 3, 0, 0);
    do_op(2, 3, 5, 0, 2, 0, 0);
    do_op(7, 8'h81, 1, 0, 2, 0, 0);
    do_op(8, 8'h81, 0, 0, 2, 0, 0);
    do_op(9, 255, 255, 255, 3, 0, 0);

    // simultaneous put_en+op_en is dropped and leaves the count alone
    @(negedge clk); put_en = 1'b1; cnt_m = 1;
    @(negedge clk); op_en = 1'b1; opcode = 4'd1;
    @(negedge clk); put_en = 1'b0; op_en = 1'b0;
    check("simul_no_valid", result_valid, 0);
    check("simul_no_err", err_operands, 0);
    check("simul_idle", busy, 0);
    do_op(1, 5, 6, 0, 0, 0, 0);

    // reset in the middle of a multiply
    repeat (2) begin @(negedge clk); put_en = 1'b1; end
    @(negedge clk); put_en = 1'b0; op_en = 1'b1; opcode = 4'd10; r0 = 8'd13; r1 = 8'd11;
    @(negedge clk); op_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", result_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    @(negedge clk); rst_n = 1'b1;
    cnt_m = 0;
    do_op(1, 1, 2, 0, 0, 0, 0);
    do_op(1, 1, 2, 0, 2, 0, 0);

    for (int i = 0; i < 40; i++) begin
      opc = $urandom_range(0, 15);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      c = $urandom_range(0, 255);
      do_op(opc, a, b, c, $urandom_range(0, 3), $urandom_range(0, 2), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
